// File: rtl/hue_pkg.sv
// Shared definitions for the hue pipeline stages: function codes carried as
// sideband tags, per-beat flag bundle, and the divider latency helper.
package hue_pkg;

  // Hue function codes, carried through the divider as the opaque tag.
  localparam logic [1:0] HUE_FN_R    = 2'd0;
  localparam logic [1:0] HUE_FN_G    = 2'd1;
  localparam logic [1:0] HUE_FN_B    = 2'd2;
  localparam logic [1:0] HUE_FN_NONE = 2'd3;

  // Per-beat flags decided in the input stage and carried to the output.
  typedef struct packed {
    logic dbz;   // denominator was zero
    logic sat;   // |num| >= den, quotient clamps to all ones
    logic sign;  // result is negative (already masked for dbz and zero)
  } div_flags_t;

  // Cycles from an accepted input to o_valid with no stall:
  // input stage + one stage per fraction bit + output register.
  function automatic int hue_div_latency(input int frac_w);
    return frac_w + 2;
  endfunction

endpackage

// File: rtl/hue_div_step.sv
// One registered restoring-division step: doubles the remainder, subtracts
// the divisor when it fits, and shifts the resulting bit into the quotient.
// Divisor, flags and tag ride along unchanged.
module hue_div_step
  import hue_pkg::*;
#(
  parameter int DEN_W  = 8,
  parameter int FRAC_W = 15,
  parameter int TAG_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [DEN_W:0]    i_rem,
  input  logic [DEN_W-1:0]  i_den,
  input  logic [FRAC_W-1:0] i_quot,
  input  div_flags_t        i_flags,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  output logic [DEN_W:0]    o_rem,
  output logic [DEN_W-1:0]  o_den,
  output logic [FRAC_W-1:0] o_quot,
  output div_flags_t        o_flags,
  output logic [TAG_W-1:0]  o_tag
);

  logic [DEN_W+1:0]  w_rem2;
  logic              w_fits;
  logic [DEN_W:0]    w_rem_next;
  logic [FRAC_W-1:0] w_quot_next;

  logic              r_valid;
  logic [DEN_W:0]    r_rem;
  logic [DEN_W-1:0]  r_den;
  logic [FRAC_W-1:0] r_quot;
  div_flags_t        r_flags;
  logic [TAG_W-1:0]  r_tag;

  // Restoring step: compare 2r against den on the full width so the top bit
  // of a saturating beat cannot alias; the kept remainder fits in DEN_W+1.
  // NOTE: every signal gets a value on every path through always_comb, so no
  // latch can be inferred.
  always_comb begin
    w_rem2         = {i_rem, 1'b0};
    w_fits         = (w_rem2 >= {2'b00, i_den});
    w_rem_next     = w_fits ? (w_rem2[DEN_W:0] - {1'b0, i_den}) : w_rem2[DEN_W:0];
    w_quot_next    = i_quot << 1;
    w_quot_next[0] = w_fits;
  end

  // Beat-valid bit: cleared by reset, advances only on global enable.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
    end
  end

  // Datapath payload: advances with the valid bit, holds on stall.
  // NOTE: payload flops are not reset; the valid bit alone qualifies them,
  // so resetting them would add reset fan-out for no behavioural gain.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_rem   <= w_rem_next;
      r_den   <= i_den;
      r_quot  <= w_quot_next;
      r_flags <= i_flags;
      r_tag   <= i_tag;
    end
  end

  assign o_valid = r_valid;
  assign o_rem   = r_rem;
  assign o_den   = r_den;
  assign o_quot  = r_quot;
  assign o_flags = r_flags;
  assign o_tag   = r_tag;

endmodule

// File: rtl/hue_div_pipe.sv
// Pipelined saturating divider for the hue stage: |num| * 2^FRAC_W / den with
// sign, divide-by-zero flag and a pass-through tag. One beat per cycle, with
// a single global advance enable driven by downstream backpressure.
module hue_div_pipe
  import hue_pkg::*;
#(
  parameter int NUM_W  = 8,
  parameter int DEN_W  = 8,
  parameter int FRAC_W = 15,
  parameter int TAG_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_W:0]    i_num,
  input  logic [DEN_W-1:0]  i_den,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [FRAC_W-1:0] o_quot,
  output logic              o_sign,
  output logic              o_dbz,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_valid,
  input  logic              i_ready
);

  // Whole pipeline moves together whenever the output slot is free or drained.
  logic w_en;
  logic r_o_valid;

  assign w_en    = i_ready | ~r_o_valid;
  assign o_ready = w_en;

  // ---------------------------------------------------------------- S0
  logic             w_s;
  logic [NUM_W:0]   w_a;
  logic [DEN_W:0]   w_a_ext;
  div_flags_t       w_s0_flags;

  logic             r_s0_valid;
  logic [DEN_W:0]   r_s0_rem;
  logic [DEN_W-1:0] r_s0_den;
  div_flags_t       r_s0_flags;
  logic [TAG_W-1:0] r_s0_tag;

  // Magnitude, sign and special-case flags of the incoming beat; the most
  // negative numerator maps to 2^NUM_W, which still fits in NUM_W+1 bits.
  always_comb begin
    w_s             = i_num[NUM_W];
    w_a             = w_s ? (~i_num + (NUM_W+1)'(1)) : i_num;
    w_a_ext         = (DEN_W+1)'(w_a);
    w_s0_flags.dbz  = (i_den == '0);
    w_s0_flags.sat  = ~w_s0_flags.dbz & (w_a_ext >= {1'b0, i_den});
    w_s0_flags.sign = w_s & ~w_s0_flags.dbz & (w_a != '0);
  end

  // Input-stage valid: a beat is taken whenever the pipeline advances.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s0_valid <= 1'b0;
    end else if (w_en) begin
      r_s0_valid <= i_valid;
    end
  end

  // Input-stage payload: initial remainder is |num|, divisor and flags latch.
  always_ff @(posedge i_clk) begin
    if (w_en) begin
      r_s0_rem   <= w_a_ext;
      r_s0_den   <= i_den;
      r_s0_flags <= w_s0_flags;
      r_s0_tag   <= i_tag;
    end
  end

  // ---------------------------------------------------------------- S1..S(FRAC_W)
  logic              w_valid [1:FRAC_W];
  logic [DEN_W:0]    w_rem   [1:FRAC_W];
  logic [DEN_W-1:0]  w_den   [1:FRAC_W];
  logic [FRAC_W-1:0] w_quot  [1:FRAC_W];
  div_flags_t        w_flags [1:FRAC_W];
  logic [TAG_W-1:0]  w_tag   [1:FRAC_W];

  for (genvar k = 1; k <= FRAC_W; k++) begin : g_step
    logic              w_v_in;
    logic [DEN_W:0]    w_r_in;
    logic [DEN_W-1:0]  w_d_in;
    logic [FRAC_W-1:0] w_q_in;
    div_flags_t        w_f_in;
    logic [TAG_W-1:0]  w_t_in;

    if (k == 1) begin : g_head
      assign w_v_in = r_s0_valid;
      assign w_r_in = r_s0_rem;
      assign w_d_in = r_s0_den;
      assign w_q_in = '0;
      assign w_f_in = r_s0_flags;
      assign w_t_in = r_s0_tag;
    end else begin : g_body
      assign w_v_in = w_valid[k-1];
      assign w_r_in = w_rem[k-1];
      assign w_d_in = w_den[k-1];
      assign w_q_in = w_quot[k-1];
      assign w_f_in = w_flags[k-1];
      assign w_t_in = w_tag[k-1];
    end

    hue_div_step #(
      .DEN_W  (DEN_W),
      .FRAC_W (FRAC_W),
      .TAG_W  (TAG_W)
    ) u_step (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (w_en),
      .i_valid (w_v_in),
      .i_rem   (w_r_in),
      .i_den   (w_d_in),
      .i_quot  (w_q_in),
      .i_flags (w_f_in),
      .i_tag   (w_t_in),
      .o_valid (w_valid[k]),
      .o_rem   (w_rem[k]),
      .o_den   (w_den[k]),
      .o_quot  (w_quot[k]),
      .o_flags (w_flags[k]),
      .o_tag   (w_tag[k])
    );
  end

  // The final remainder and divisor are not needed past the last step.
  logic w_unused_tail;
  assign w_unused_tail = ^{w_rem[FRAC_W], w_den[FRAC_W]};

  // ---------------------------------------------------------------- output
  logic [FRAC_W-1:0] w_quot_out;
  logic [FRAC_W-1:0] r_o_quot;
  logic              r_o_sign;
  logic              r_o_dbz;
  logic [TAG_W-1:0]  r_o_tag;

  // Final quotient selection: zero on divide-by-zero, clamp on saturation.
  always_comb begin
    w_quot_out = w_quot[FRAC_W];
    if (w_flags[FRAC_W].dbz) begin
      w_quot_out = '0;
    end else if (w_flags[FRAC_W].sat) begin
      w_quot_out = '1;
    end
  end

  // Output register: data only loads with a real beat, so it holds otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_o_valid <= 1'b0;
      r_o_quot  <= '0;
      r_o_sign  <= 1'b0;
      r_o_dbz   <= 1'b0;
      r_o_tag   <= '0;
    end else if (w_en) begin
      r_o_valid <= w_valid[FRAC_W];
      if (w_valid[FRAC_W]) begin
        r_o_quot <= w_quot_out;
        r_o_sign <= w_flags[FRAC_W].sign;
        r_o_dbz  <= w_flags[FRAC_W].dbz;
        r_o_tag  <= w_tag[FRAC_W];
      end
    end
  end

  assign o_valid = r_o_valid;
  assign o_quot  = r_o_quot;
  assign o_sign  = r_o_sign;
  assign o_dbz   = r_o_dbz;
  assign o_tag   = r_o_tag;

endmodule

// File: tb/tb_hue_div_pipe.sv
// Self-checking bench for hue_div_pipe: directed literal cases, a randomized
// backpressured stream against an arithmetic reference model, and a
// mid-stream reset.
module tb_hue_div_pipe;
  import hue_pkg::*;

  localparam int NUM_W  = 8;
  localparam int DEN_W  = 8;
  localparam int FRAC_W = 15;
  localparam int TAG_W  = 2;
  localparam int LAT    = hue_div_latency(FRAC_W);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_W:0]    i_num = '0;
  logic [DEN_W-1:0]  i_den = '0;
  logic [TAG_W-1:0]  i_tag = '0;
  logic              i_valid = 1'b0;
  logic              i_ready = 1'b1;
  logic              o_ready;
  logic [FRAC_W-1:0] o_quot;
  logic              o_sign;
  logic              o_dbz;
  logic [TAG_W-1:0]  o_tag;
  logic              o_valid;

  hue_div_pipe #(
    .NUM_W (NUM_W), .DEN_W (DEN_W), .FRAC_W (FRAC_W), .TAG_W (TAG_W)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_num   (i_num),
    .i_den   (i_den),
    .i_tag   (i_tag),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_quot  (o_quot),
    .o_sign  (o_sign),
    .o_dbz   (o_dbz),
    .o_tag   (o_tag),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [FRAC_W-1:0] quot;
    logic              sign;
    logic              dbz;
    logic [TAG_W-1:0]  tag;
  } exp_t;

  function automatic exp_t model(input logic [NUM_W:0] num, input logic [DEN_W-1:0] den,
                                 input logic [TAG_W-1:0] tag);
    exp_t   e;
    longint n, a, q, qmax;
    n    = longint'($signed(num));
    a    = (n < 0) ? -n : n;
    qmax = (longint'(1) << FRAC_W) - 1;
    e.tag = tag;
    if (den == 0) begin
      e.quot = '0;
      e.sign = 1'b0;
      e.dbz  = 1'b1;
    end else begin
      q = (a * (longint'(1) << FRAC_W)) / longint'(den);
      if (q > qmax) q = qmax;
      e.quot = q[FRAC_W-1:0];
      e.sign = (n < 0);
      e.dbz  = 1'b0;
    end
    return e;
  endfunction

  exp_t exp_q[$];

  // ---------------------------------------------------------------- compare process
  logic              stalled = 1'b0;
  logic [FRAC_W-1:0] held_quot;
  logic              held_sign, held_dbz;
  logic [TAG_W-1:0]  held_tag;

  // Checks every handshake against the model queue, and output stability
  // plus o_ready while the output is stalled. Samples mid low-phase.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_hold_quot", o_quot, held_quot);
        check("stall_hold_sign", o_sign, held_sign);
        check("stall_hold_dbz",  o_dbz,  held_dbz);
        check("stall_hold_tag",  o_tag,  held_tag);
        check("stall_hold_valid", o_valid, 1'b1);
      end
      if (o_valid && !i_ready) begin
        check("stall_o_ready", o_ready, 1'b0);
        stalled   = 1'b1;
        held_quot = o_quot;
        held_sign = o_sign;
        held_dbz  = o_dbz;
        held_tag  = o_tag;
      end else begin
        stalled = 1'b0;
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_quot", o_quot, e.quot);
          check("sb_sign", o_sign, e.sign);
          check("sb_dbz",  o_dbz,  e.dbz);
          check("sb_tag",  o_tag,  e.tag);
        end
      end
      if (i_valid && o_ready) exp_q.push_back(model(i_num, i_den, i_tag));
    end
  end

  // ---------------------------------------------------------------- directed helper
  // Sends one beat with i_ready high and returns the result and its latency.
  task automatic send_and_wait(input logic [NUM_W:0] num, input logic [DEN_W-1:0] den,
                               input logic [TAG_W-1:0] tag,
                               output logic [FRAC_W-1:0] q, output logic s,
                               output logic z, output logic [TAG_W-1:0] t, output int lat);
    @(negedge clk);
    i_ready = 1'b1;
    i_num   = num;
    i_den   = den;
    i_tag   = tag;
    i_valid = 1'b1;
    #2;
    check("accept_ready", o_ready, 1'b1);
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 4 * LAT) begin
      @(negedge clk);
      lat++;
    end
    q = o_quot;
    s = o_sign;
    z = o_dbz;
    t = o_tag;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- main sequence
  initial begin
    logic [FRAC_W-1:0] q;
    logic              s, z;
    logic [TAG_W-1:0]  t;
    int                lat;
    exp_t              m;

    // Pin the reference model to hand-computed values.
    m = model(9'd64, 8'd128, HUE_FN_R);
    check("model_64_128", m.quot, 15'h4000);
    m = model(9'h1E0, 8'd96, HUE_FN_B);
    check("model_m32_96", {m.sign, m.quot}, {1'b1, 15'd10922});
    m = model(9'd6, 8'd7, HUE_FN_R);
    check("model_6_7", m.quot, 15'd28086);
    m = model(9'h100, 8'd255, HUE_FN_R);
    check("model_m256_255", {m.sign, m.quot}, {1'b1, 15'h7FFF});

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_valid", o_valid, 1'b0);
    check("rst_quot", o_quot, '0);
    check("rst_sign", o_sign, 1'b0);
    check("rst_dbz", o_dbz, 1'b0);
    check("rst_tag", o_tag, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: 64/128 = 0.5.
    send_and_wait(9'd64, 8'd128, HUE_FN_R, q, s, z, t, lat);
    check("t1_latency", lat, LAT);
    check("t1_quot", q, 15'h4000);
    check("t1_sign", s, 1'b0);
    check("t1_dbz", z, 1'b0);

    // 2: -32/96, tag 2.
    send_and_wait(9'h1E0, 8'd96, HUE_FN_B, q, s, z, t, lat);
    check("t2_quot", q, 15'd10922);
    check("t2_sign", s, 1'b1);
    check("t2_tag", t, 2'd2);

    // 3: divide by zero, saturation, most negative numerator.
    send_and_wait(9'd50, 8'd0, HUE_FN_G, q, s, z, t, lat);
    check("t3a_dbz", z, 1'b1);
    check("t3a_quot", q, '0);
    check("t3a_sign", s, 1'b0);
    send_and_wait(9'd200, 8'd100, HUE_FN_R, q, s, z, t, lat);
    check("t3b_quot", q, 15'h7FFF);
    check("t3b_dbz", z, 1'b0);
    send_and_wait(9'h100, 8'd255, HUE_FN_NONE, q, s, z, t, lat);
    check("t3c_quot", q, 15'h7FFF);
    check("t3c_sign", s, 1'b1);
    check("t3c_tag", t, 2'd3);

    // 5: zero numerator and a non-terminating fraction.
    send_and_wait(9'd0, 8'd7, HUE_FN_R, q, s, z, t, lat);
    check("t5a_quot", q, '0);
    check("t5a_sign", s, 1'b0);
    send_and_wait(9'd6, 8'd7, HUE_FN_R, q, s, z, t, lat);
    check("t5b_quot", q, 15'd28086);

    // 4: 40 random beats back-to-back under random backpressure,
    // with a forced 5-cycle i_ready low run.
    begin
      int sent = 0;
      int cyc  = 0;
      @(negedge clk);
      i_num   = 9'($urandom_range(0, 511));
      i_den   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      i_tag   = 2'($urandom_range(0, 3));
      while (sent < 40 && cyc < 2000) begin
        i_valid = 1'b1;
        i_ready = (cyc >= 20 && cyc < 25) ? 1'b0 : ($urandom_range(0, 2) != 0);
        #2;
        if (o_ready) sent++;
        @(negedge clk);
        cyc++;
        if (o_ready || !i_valid) begin
          i_num = 9'($urandom_range(0, 511));
          i_den = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
          i_tag = 2'($urandom_range(0, 3));
        end
      end
      check("t4_all_sent", sent, 40);
      i_valid = 1'b0;
      i_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      repeat (2) @(negedge clk);
      check("t4_drained", exp_q.size(), 0);
    end

    // 6: reset with 10 beats in flight, some already at the output.
    begin
      int cyc = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        i_ready = 1'b1;
        i_num   = 9'($urandom_range(0, 511));
        i_den   = 8'($urandom_range(1, 255));
        i_tag   = 2'($urandom_range(0, 3));
        i_valid = 1'b1;
      end
      @(negedge clk);
      i_valid = 1'b0;
      while (!o_valid && cyc < 4 * LAT) begin
        @(negedge clk);
        cyc++;
      end
      check("t6_pre_valid", o_valid, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6_valid_drop", o_valid, 1'b0);
      check("t6_quot_clear", o_quot, '0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        check("t6_no_ghost", o_valid, 1'b0);
      end
      send_and_wait(9'h1F9, 8'd21, HUE_FN_G, q, s, z, t, lat);
      check("t6_latency", lat, LAT);
      check("t6_quot", q, 15'd10922);
      check("t6_sign", s, 1'b1);
      check("t6_tag", t, 2'd1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
